// File: rtl/axicb_wr_ingress.sv
`default_nettype none
// =============================================================================
// axicb_wr_ingress: AW skid buffer, W FIFO and B slice for one write master port.
// Macro AXICB_WR_INGRESS_WGATE_EN holds W beats until their AW has been forwarded.
// Revision: 1.0
// =============================================================================
module axicb_wr_ingress #(
    parameter int AWCH_W          = 8,
    parameter int WCH_W           = 8,
    parameter int BCH_W           = 10,
    parameter int MST_OSTDREQ_NUM = 4,
    parameter int WFIFO_DEPTH     = 8
) (
    input  logic                                       aclk,
    input  logic                                       srst,
    input  logic                                       s_awvalid,
    output logic                                       s_awready,
    input  logic [AWCH_W-1:0]                          s_awch,
    input  logic                                       s_wvalid,
    output logic                                       s_wready,
    input  logic                                       s_wlast,
    input  logic [WCH_W-1:0]                           s_wch,
    output logic                                       s_bvalid,
    input  logic                                       s_bready,
    output logic [BCH_W-1:0]                           s_bch,
    output logic                                       m_awvalid,
    input  logic                                       m_awready,
    output logic [AWCH_W-1:0]                          m_awch,
    output logic                                       m_wvalid,
    input  logic                                       m_wready,
    output logic                                       m_wlast,
    output logic [WCH_W-1:0]                           m_wch,
    input  logic                                       m_bvalid,
    output logic                                       m_bready,
    input  logic [BCH_W-1:0]                           m_bch,
    output logic [$clog2(MST_OSTDREQ_NUM+1)-1:0]       o_ostd_cnt
);

    localparam int                OSTD_W   = $clog2(MST_OSTDREQ_NUM + 1);
    localparam int                PTR_W    = $clog2(WFIFO_DEPTH);
    localparam logic [OSTD_W-1:0] OSTD_MAX = OSTD_W'(MST_OSTDREQ_NUM);

    // ---------------- AW skid buffer ----------------
    logic [1:0]        aw_cnt;
    logic [AWCH_W-1:0] aw_q0;
    logic [AWCH_W-1:0] aw_q1;
    logic              aw_push;
    logic              aw_pop;
    logic [OSTD_W-1:0] ostd_cnt;

    assign s_awready = (aw_cnt != 2'd2) && (ostd_cnt < OSTD_MAX);
    assign aw_push   = s_awvalid && s_awready;
    assign m_awvalid = (aw_cnt != 2'd0);
    assign aw_pop    = m_awvalid && m_awready;
    assign m_awch    = aw_q0;

    always_ff @(posedge aclk) begin
        if (srst) aw_cnt <= 2'd0;
        else      aw_cnt <= aw_cnt + {1'b0, aw_push} - {1'b0, aw_pop};
    end

    // Head entry only changes on a pop or when loading an empty buffer.
    always_ff @(posedge aclk) begin
        if (aw_pop)                            aw_q0 <= (aw_cnt == 2'd2) ? aw_q1 : s_awch;
        else if (aw_push && aw_cnt == 2'd0)    aw_q0 <= s_awch;
        if (aw_push && !aw_pop && aw_cnt == 2'd1) aw_q1 <= s_awch;
    end

    // ---------------- Outstanding counter ----------------
    logic b_out_hs;
    assign b_out_hs   = s_bvalid && s_bready;
    assign o_ostd_cnt = ostd_cnt;

    always_ff @(posedge aclk) begin
        if (srst)                                       ostd_cnt <= '0;
        else if (aw_push && !b_out_hs)                  ostd_cnt <= ostd_cnt + OSTD_W'(1);
        else if (!aw_push && b_out_hs && ostd_cnt != '0) ostd_cnt <= ostd_cnt - OSTD_W'(1);
    end

    // ---------------- W FIFO ----------------
    logic [WCH_W:0]   wmem [WFIFO_DEPTH];
    logic [PTR_W:0]   wr_ptr;
    logic [PTR_W:0]   rd_ptr;
    logic             w_empty;
    logic             w_full;
    logic             w_push;
    logic             w_pop;

    assign w_empty  = (wr_ptr == rd_ptr);
    assign w_full   = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                      (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    assign s_wready = !w_full;
    assign w_push   = s_wvalid && s_wready;
    assign w_pop    = m_wvalid && m_wready;
    assign {m_wlast, m_wch} = wmem[rd_ptr[PTR_W-1:0]];

    always_ff @(posedge aclk) begin
        if (srst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (w_push) wr_ptr <= wr_ptr + (PTR_W+1)'(1);
            if (w_pop)  rd_ptr <= rd_ptr + (PTR_W+1)'(1);
        end
    end

    always_ff @(posedge aclk) begin
        if (w_push) wmem[wr_ptr[PTR_W-1:0]] <= {s_wlast, s_wch};
    end

`ifdef AXICB_WR_INGRESS_WGATE_EN
    // One credit per forwarded AW, returned by the last beat of its burst.
    logic [OSTD_W-1:0] aw_credit;
    logic              wlast_hs;
    assign wlast_hs = w_pop && m_wlast;
    assign m_wvalid = !w_empty && (aw_credit != '0);

    always_ff @(posedge aclk) begin
        if (srst)                      aw_credit <= '0;
        else if (aw_pop && !wlast_hs)  aw_credit <= aw_credit + OSTD_W'(1);
        else if (!aw_pop && wlast_hs)  aw_credit <= aw_credit - OSTD_W'(1);
    end
`else
    assign m_wvalid = !w_empty;
`endif

    // ---------------- B register slice ----------------
    logic             b_full;
    logic [BCH_W-1:0] b_data;
    logic             b_load;

    assign m_bready = !b_full || s_bready;
    assign b_load   = m_bvalid && m_bready;
    assign s_bvalid = b_full;
    assign s_bch    = b_data;

    always_ff @(posedge aclk) begin
        if (srst)          b_full <= 1'b0;
        else if (b_load)   b_full <= 1'b1;
        else if (b_out_hs) b_full <= 1'b0;
    end

    always_ff @(posedge aclk) begin
        if (b_load) b_data <= m_bch;
    end

endmodule
`default_nettype wire
